// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer: host command sequencer that drives the accelerator's
// memory-lane control word, lane data and start/eoc pulses; returns reads.
module mem_lane_sequencer #(
  parameter int memDataLen       = 16,
  parameter int numMemLanes      = 16,
  parameter int logMemNamespaces = 2,
  parameter int logNumPeMemLanes = 2,
  parameter int rdLatency        = 8,
  parameter int cntLen           = 16,
  localparam int memCtrlIn =
    logMemNamespaces + (logNumPeMemLanes + 1) * numMemLanes,
  localparam int W = memDataLen * numMemLanes
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [logMemNamespaces-1:0] cmd_ns,
  input  logic [cntLen-1:0]           cmd_beats,
  input  logic [W-1:0]                wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [W-1:0]                rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        start,
  output logic                        eoc,
  output logic [memCtrlIn-1:0]        mem_ctrl_in,
  output logic                        mem_rd_wrt,
  output logic [W-1:0]                mem_data_input,
  input  logic [W-1:0]                mem_data_output,
  input  logic                        eol
);

  localparam int PW = logNumPeMemLanes;
  localparam int FW = logNumPeMemLanes + 1;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_COMPUTE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_COMPUTE,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [logMemNamespaces-1:0] ns_q, ns_d;
  logic [cntLen-1:0]           remaining_q, remaining_d;
  logic [cntLen-1:0]           inflight_q, inflight_d;
  logic [PW-1:0]               pe_sel_q, pe_sel_d;
  logic [rdLatency-1:0]        flag_sr_q, flag_sr_d;

  logic                        cmd_ready_q, cmd_ready_d;
  logic                        wr_ready_q, wr_ready_d;
  logic [W-1:0]                rd_data_q, rd_data_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        start_q, start_d;
  logic                        eoc_q, eoc_d;
  logic [memCtrlIn-1:0]        ctrl_q, ctrl_d;
  logic                        rd_wrt_q, rd_wrt_d;
  logic [W-1:0]                din_q, din_d;

  logic [memCtrlIn-1:0]        lane_ctrl;
  logic                        issue;
  logic                        emerge;

  // Active lane word: every lane valid, all lanes share the current PE select.
  always_comb begin
    lane_ctrl = '0;
    lane_ctrl[logMemNamespaces-1:0] = ns_q;
    for (int i = 0; i < numMemLanes; i++) begin
      lane_ctrl[logMemNamespaces + FW*i +: FW] = {pe_sel_q, 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    ns_d        = ns_q;
    remaining_d = remaining_q;
    pe_sel_d    = pe_sel_q;
    ctrl_d      = '0;
    rd_wrt_d    = 1'b0;
    din_d       = '0;
    start_d     = 1'b0;
    eoc_d       = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    issue       = 1'b0;

    // Flag enters the pipe while the read is on the lane bus.
    emerge       = flag_sr_q[rdLatency-1];
    flag_sr_d    = flag_sr_q << 1;
    flag_sr_d[0] = rd_wrt_q;

    if (emerge) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_data_output;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ns_d        = cmd_ns;
          remaining_d = cmd_beats;
          pe_sel_d    = '0;
          unique case (cmd_op)
            OP_WRITE:
              state_d = (cmd_beats == '0) ? S_DONE : S_WRITE;
            OP_READ:
              state_d = (cmd_beats == '0) ? S_DONE : S_READ;
            OP_COMPUTE: begin
              state_d = S_COMPUTE;
              start_d = 1'b1;
            end
            default: begin
              state_d = S_DONE;
              eoc_d   = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (wr_valid && wr_ready_q) begin
          ctrl_d      = lane_ctrl;
          din_d       = wr_data;
          pe_sel_d    = pe_sel_q + PW'(1);
          remaining_d = remaining_q - cntLen'(1);
        end
      end
      S_READ: begin
        issue       = 1'b1;
        ctrl_d      = lane_ctrl;
        rd_wrt_d    = 1'b1;
        pe_sel_d    = pe_sel_q + PW'(1);
        remaining_d = remaining_q - cntLen'(1);
        if (remaining_q == cntLen'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_q == '0) state_d = S_DONE;
      end
      S_COMPUTE: begin
        if (!start_q && eol) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    inflight_d  = inflight_q + cntLen'(issue) - cntLen'(emerge);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    wr_ready_d  = (state_d == S_WRITE) && (remaining_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ns_q        <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      pe_sel_q    <= '0;
      flag_sr_q   <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      eoc_q       <= 1'b0;
      ctrl_q      <= '0;
      rd_wrt_q    <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      ns_q        <= ns_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      pe_sel_q    <= pe_sel_d;
      flag_sr_q   <= flag_sr_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start_d;
      eoc_q       <= eoc_d;
      ctrl_q      <= ctrl_d;
      rd_wrt_q    <= rd_wrt_d;
      din_q       <= din_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign wr_ready       = wr_ready_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign start          = start_q;
  assign eoc            = eoc_q;
  assign mem_ctrl_in    = ctrl_q;
  assign mem_rd_wrt     = rd_wrt_q;
  assign mem_data_input = din_q;

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// tb_mem_lane_sequencer: directed + randomized command sequences checked
// against a transaction-level model of lanes, read returns and pulses.
module tb_mem_lane_sequencer;

  localparam int NL  = 16;
  localparam int LNS = 2;
  localparam int LPE = 2;
  localparam int RDL = 8;
  localparam int MCI = LNS + (LPE + 1) * NL;
  localparam int W   = 16 * NL;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [LNS-1:0] cmd_ns;
  logic [15:0]    cmd_beats;
  logic [W-1:0]   wr_data;
  logic           wr_valid;
  logic           wr_ready;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic           busy;
  logic           done;
  logic           start;
  logic           eoc;
  logic [MCI-1:0] mem_ctrl_in;
  logic           mem_rd_wrt;
  logic [W-1:0]   mem_data_input;
  logic [W-1:0]   mem_data_output;
  logic           eol;

  int          cyc   = 0;
  logic [15:0] salt  = 16'h0;
  int          n_vec = 0;
  int          n_err = 0;

  mem_lane_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_ns          (cmd_ns),
    .cmd_beats       (cmd_beats),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .busy            (busy),
    .done            (done),
    .start           (start),
    .eoc             (eoc),
    .mem_ctrl_in     (mem_ctrl_in),
    .mem_rd_wrt      (mem_rd_wrt),
    .mem_data_input  (mem_data_input),
    .mem_data_output (mem_data_output),
    .eol             (eol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accelerator read port: cycle number (salted), replicated on every lane.
  assign mem_data_output = {NL{cyc[15:0] ^ salt}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Lane word for beat k: namespace, then per lane {pe = k mod 4, valid}.
  function automatic logic [MCI-1:0] exp_ctrl(input int ns, input int k);
    logic [MCI-1:0] w;
    int f;
    f = (k % (1 << LPE)) * 2 + 1;
    w = MCI'(ns);
    for (int i = 0; i < NL; i++)
      w = w | (MCI'(f) << (LNS + (LPE + 1) * i));
    return w;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input int ns,
                         input int beats, input bit rnd, input int gap,
                         input int eol_after, input bit eol_in_start,
                         input bit keep_valid,
                         output int acc, output int done_cyc);
    logic [W-1:0] wdat[$];
    int issue_q[$];
    int t, cur, lanes, first_lane, last_lane, last_rv;
    int beat_in, starts, eocs, rvs;
    bit gapped;
    for (int j = 0; j < beats; j++) begin
      if (rnd) wdat.push_back(rnd_word());
      else wdat.push_back({NL{16'(j + 1)}});
    end
    cmd_op    = op;
    cmd_ns    = LNS'(ns);
    cmd_beats = 16'(beats);
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      tick();
      t++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    acc = cyc;
    done_cyc = -1;
    lanes = 0;
    first_lane = -1;
    last_lane = -1;
    last_rv = -1;
    beat_in = 0;
    starts = 0;
    eocs = 0;
    rvs = 0;
    gapped = 0;
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      cur = cyc;
      if (mem_ctrl_in[LNS]) begin
        if (lanes < beats) begin
          chk("lane_ctrl", mem_ctrl_in, exp_ctrl(ns, lanes));
          chk("lane_rd_wrt", mem_rd_wrt, (op == 2'd1));
          if (op == 2'd1) chk("lane_rd_data", mem_data_input, 0);
          else chk("lane_wr_data", mem_data_input, wdat[lanes]);
        end else begin
          chki("lane_count_live", lanes + 1, beats);
        end
        if (op == 2'd1) issue_q.push_back(cur);
        if (first_lane < 0) first_lane = cur;
        last_lane = cur;
        lanes++;
      end
      if (rd_valid) begin
        if (issue_q.size() > 0) begin
          t = issue_q.pop_front();
          chki("rv_cycle", cur, t + RDL + 1);
          chk("rv_data", rd_data, {NL{16'(t + RDL) ^ salt}});
        end else begin
          chk("rv_spurious", rd_valid, 0);
        end
        last_rv = cur;
        rvs++;
      end
      if (start) begin
        starts++;
        chki("start_cycle", cur, acc + 1);
      end
      if (eoc) begin
        eocs++;
        chki("eoc_cycle", cur, acc + 1);
      end
      if (op != 2'd0) chk("wr_ready_off", wr_ready, 0);
      chk("ready_low", cmd_ready, 0);
      if (done) done_cyc = cur;
      eol = (op == 2'd2) &&
            ((cur == acc + 1 + eol_after) ||
             (eol_in_start && cur == acc + 1));
      wr_valid = 1'b0;
      if (op == 2'd0 && beat_in < beats) begin
        if (beat_in == gap && !gapped) begin
          gapped = 1'b1;
        end else begin
          wr_valid = 1'b1;
          wr_data  = wdat[beat_in];
        end
      end else if (op != 2'd0) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = rnd_word();
      end
      if (wr_valid && wr_ready && op == 2'd0) beat_in++;
      if (done_cyc < 0) tick();
    end
    eol = 1'b0;
    wr_valid = 1'b0;
    chki("done_seen", int'(done_cyc >= 0), 1);
    chki("lane_count", lanes, (op < 2'd2) ? beats : 0);
    chki("start_count", starts, int'(op == 2'd2));
    chki("eoc_count", eocs, int'(op == 2'd3));
    case (op)
      2'd0: begin
        if (beats > 0) chki("wr_done_cyc", done_cyc, last_lane + 1);
        else chki("wr0_done_cyc", done_cyc, acc + 1);
      end
      2'd1: begin
        chki("rd_returns", rvs, beats);
        if (beats > 0) begin
          chki("rd_issue_span", last_lane - first_lane, beats - 1);
          chki("rd_done_cyc", done_cyc, last_rv + 1);
        end else begin
          chki("rd0_done_cyc", done_cyc, acc + 1);
        end
      end
      2'd2: chki("cmp_done_cyc", done_cyc, acc + eol_after + 2);
      default: chki("eoc_done_cyc", done_cyc, acc + 1);
    endcase
  endtask

  initial begin
    int a1, d1, a2, d2, t, bad;
    logic [1:0] op;
    salt      = 16'($urandom);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_ns    = '0;
    cmd_beats = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    eol       = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_flags",
        {wr_ready, rd_valid, busy, done, start, eoc, mem_rd_wrt}, 0);
    chk("rst_ctrl", mem_ctrl_in, 0);
    chk("rst_din", mem_data_input, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    run_cmd(2'd0, 1, 5, 1'b0, 2, 0, 1'b0, 1'b1, a1, d1);
    run_cmd(2'd3, 0, 0, 1'b0, -1, 0, 1'b0, 1'b0, a2, d2);
    chki("held_valid_accept", a2, d1 + 1);
    run_cmd(2'd0, 2, 0, 1'b1, -1, 0, 1'b0, 1'b0, a1, d1);
    run_cmd(2'd1, 3, 4, 1'b0, -1, 0, 1'b0, 1'b0, a1, d1);

    tick();
    eol = 1'b1;
    tick();
    eol = 1'b0;
    chk("idle_eol", {busy, done, start}, 0);
    run_cmd(2'd2, 0, 0, 1'b0, -1, 20, 1'b1, 1'b0, a1, d1);

    for (int r = 0; r < 12; r++) begin
      op = 2'($urandom_range(0, 3));
      run_cmd(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
              1'b1, int'($urandom_range(0, 6)),
              int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a1, d1);
    end
    run_cmd(2'd1, 1, 0, 1'b0, -1, 0, 1'b0, 1'b0, a1, d1);

    cmd_op    = 2'd1;
    cmd_ns    = 2'd2;
    cmd_beats = 16'd10;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      tick();
      t++;
    end
    tick();
    cmd_valid = 1'b0;
    t = 0;
    while (!mem_ctrl_in[LNS] && t < 20) begin
      tick();
      t++;
    end
    chk("mid_rd_issue", mem_rd_wrt, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_flags",
        {cmd_ready, wr_ready, rd_valid, busy, done, start, eoc,
         mem_rd_wrt}, 0);
    chk("mid_rst_ctrl", mem_ctrl_in, 0);
    chk("mid_rst_din", mem_data_input, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_valid || mem_ctrl_in != '0) bad++;
    end
    chki("mid_rst_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
